// File: rtl/triumph_if_prefetch.sv
// rtl/triumph_if_prefetch.sv - instruction fetch stage with prefetch FIFO, halt, redirect and PC wrap
// Responses landing into an empty FIFO bypass straight to ID, giving request-to-valid of one cycle.
module triumph_if_prefetch #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int PC_INC     = 1,
    parameter int RESET_PC   = 0,
    parameter int PC_LIMIT   = 30,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              instr_req_o,
    output logic [ADDR_W-1:0] instr_addr_o,
    input  logic [DATA_W-1:0] instr_rdata_i,
    output logic              instr_valid_id_o,
    output logic [DATA_W-1:0] instr_data_id_o,
    output logic [ADDR_W-1:0] instr_pc_id_o,
    input  logic              id_ready_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              halt_i,
    output logic              halted_o
);
    localparam int CW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_seq;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic              issue;

    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
    logic [CW-1:0]     rd_ptr, wr_ptr;
    logic [CW:0]       count;
    logic [CW+1:0]     occ;

    logic fifo_empty, landing, pop, pop_store, push_store;

    // A response is killed by a redirect in the cycle it arrives.
    assign landing    = inflight & ~redirect_i;
    assign fifo_empty = (count == '0);
    assign pop        = instr_valid_id_o & id_ready_i;
    assign pop_store  = pop & ~fifo_empty;
    assign push_store = landing & ~(fifo_empty & pop);

    assign instr_valid_id_o = ~fifo_empty | landing;
    assign instr_data_id_o  = ~fifo_empty ? fifo_data[rd_ptr] :
                              (landing ? instr_rdata_i : '0);
    assign instr_pc_id_o    = ~fifo_empty ? fifo_pc[rd_ptr] :
                              (landing ? inflight_pc : '0);

    assign occ    = {1'b0, count} + (CW+2)'(inflight) - (CW+2)'(pop);
    assign pc_seq = (pc == ADDR_W'(PC_LIMIT)) ? ADDR_W'(RESET_PC) : pc + ADDR_W'(PC_INC);

    assign instr_req_o  = issue;
    assign instr_addr_o = pc;
    assign halted_o     = (state == HALT) & ~inflight;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (halt_i) state_nxt = HALT;
                issue = ~halt_i & ~redirect_i & (occ < (CW+2)'(FIFO_DEPTH));
            end
            HALT: if (!halt_i) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= BOOT;
            pc          <= ADDR_W'(RESET_PC);
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if (issue) inflight_pc <= pc;
            if (redirect_i) pc <= redirect_pc_i;
            else if (issue) pc <= pc_seq;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_store) wr_ptr <= wr_ptr + 1'b1;
            if (pop_store)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_store, pop_store})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (push_store) begin
            fifo_data[wr_ptr] <= instr_rdata_i;
            fifo_pc[wr_ptr]   <= inflight_pc;
        end
    end
endmodule

// File: tb/tb_triumph_if_prefetch.sv
// tb/tb_triumph_if_prefetch.sv - randomized bench with a queue-based fetch model
module tb_triumph_if_prefetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        valid_id;
    logic [31:0] data_id;
    logic [31:0] pc_id;
    logic        ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    int          ms;
    logic [31:0] mpc;
    bit          infl;
    logic [31:0] infl_pc;
    logic [31:0] q[$];
    logic [31:0] plog[$];

    always #5 clk = ~clk;

    triumph_if_prefetch #(
        .ADDR_W(32), .DATA_W(32), .PC_INC(1), .RESET_PC(0), .PC_LIMIT(30), .FIFO_DEPTH(2)
    ) dut (
        .clk_i(clk), .rst_i(rst), .instr_req_o(req), .instr_addr_o(addr),
        .instr_rdata_i(rdata), .instr_valid_id_o(valid_id), .instr_data_id_o(data_id),
        .instr_pc_id_o(pc_id), .id_ready_i(ready), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .halt_i(halt), .halted_o(halted)
    );

    always @(posedge clk) rdata <= 32'h100 + addr;

    function automatic logic [31:0] next_pc(input logic [31:0] p);
        return (p == 32'd30) ? 32'd0 : p + 32'd1;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ms   = 0;
        mpc  = 32'd0;
        infl = 1'b0;
        q.delete();
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input bit rdy, input bit hlt, input bit rd, input logic [31:0] rpc);
        logic [31:0] vis[$];
        bit e_pop, e_req;
        int occ;
        ready = rdy; halt = hlt; redirect = rd; redirect_pc = rpc;
        #1;
        vis = q;
        if (infl && !rd) vis.push_back(infl_pc);
        e_pop = (vis.size() > 0) && rdy;
        occ   = q.size() + int'(infl) - int'(e_pop);
        e_req = (ms == 1) && !hlt && !rd && (occ < 2);
        check("req", req, e_req);
        check("addr", addr, mpc);
        check("valid", valid_id, vis.size() > 0);
        if (vis.size() > 0) begin
            check("id_pc", pc_id, vis[0]);
            check("id_data", data_id, 32'h100 + vis[0]);
        end
        check("halted", halted, (ms == 2) && !infl);
        if (valid_id && rdy) plog.push_back(pc_id);
        @(posedge clk);
        if (rd) begin
            q.delete();
            infl = 1'b0;
            mpc  = rpc;
        end else begin
            if (e_pop) void'(vis.pop_front());
            q    = vis;
            infl = e_req;
            if (e_req) begin
                infl_pc = mpc;
                mpc     = next_pc(mpc);
            end
        end
        case (ms)
            0: ms = 1;
            1: if (hlt) ms = 2;
            default: if (!hlt) ms = 1;
        endcase
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_req", req, 0);
        check("rst_addr", addr, 0);
        check("rst_valid", valid_id, 0);
        check("rst_data", data_id, 0);
        check("rst_pc", pc_id, 0);
        check("rst_halted", halted, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int base;
        logic [31:0] last;
        bit hl;
        logic [31:0] rpc;
        rst = 1'b1; ready = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Sequential stream and wrap at the limit.
        for (int i = 0; i < 42; i++) step(1, 0, 0, 0);
        check("t1_count", plog.size(), 40);
        if (plog.size() >= 40) begin
            check("t1_pc0", plog[0], 32'd0);
            check("t1_pc1", plog[1], 32'd1);
            check("t1_pc2", plog[2], 32'd2);
            check("t2_pre_wrap", plog[30], 32'd30);
            check("t2_wrap", plog[31], 32'd0);
            check("t2_post_wrap", plog[32], 32'd1);
        end

        // Back-pressure.
        base = plog.size();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        check("t3_valid_held", valid_id, 1);
        check("t3_req_dropped", req, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
        for (int i = base; i < plog.size(); i++) check("t3_seq", plog[i], next_pc(plog[i-1]));

        // Redirect with buffered entries and a fetch in flight.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 1, 32'h10);
        base = plog.size();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        check("t4_got", plog.size() > base, 1);
        if (plog.size() > base + 1) begin
            check("t4_target", plog[base], 32'h10);
            check("t4_target1", plog[base+1], 32'h11);
        end

        // Halt drains, then resumes.
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        check("t5_halted", halted, 1);
        check("t5_drained", valid_id, 0);
        last = plog[plog.size()-1];
        base = plog.size();
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
        check("t5_resume", plog.size() > base, 1);
        if (plog.size() > base) check("t5_resume_pc", plog[base], next_pc(last));

        // Reset with a non-empty FIFO.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        check("t6_nonempty", valid_id, 1);
        do_reset();
        base = plog.size();
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
        check("t6_restart", plog.size() > base, 1);
        if (plog.size() > base) check("t6_restart_pc", plog[base], 32'd0);

        // Randomized traffic.
        hl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            if ($urandom_range(0, 19) == 0) hl = ~hl;
            case ($urandom_range(0, 3))
                0: rpc = 32'h10;
                1: rpc = $urandom_range(0, 40);
                2: rpc = 32'hFFFF_FFFE;
                default: rpc = $urandom;
            endcase
            step($urandom_range(0, 9) < 7, hl, $urandom_range(0, 19) == 0, rpc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
